// File: rtl/pipe_pass_detector.sv
// pipe_pass_detector: watches the bird column and tracks each pipe as it
// scrolls past. A pipe that occupied the column for at least MIN_W ticks and
// then left without a collision produces a one-cycle add pulse for the
// ones-digit score stage, and bumps a saturating binary pass total.
// Optional macro PIPE_PASS_STRETCH_EN adds passLed, a pass indicator held
// high for STRETCH clk cycles after each add pulse.
module pipe_pass_detector #(
    parameter int MIN_W   = 2,
    parameter int MAX_W   = 4,
    parameter int COUNT_W = 8,
    parameter int STRETCH = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dead,
    input  logic               tick,
    input  logic               pipeAtBird,
    output logic               add,
    output logic [COUNT_W-1:0] passCount
`ifdef PIPE_PASS_STRETCH_EN
    ,
    output logic               passLed
`endif
);

    localparam int OCC_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        IN_PIPE,
        SCORE,
        DEAD
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] nextOcc;

    // Next-state and occupancy logic: start=0 beats dead, dead beats tick handling
    always_comb begin
        nextState = state;
        nextOcc   = occ;
        if (!start) begin
            nextState = IDLE;
            nextOcc   = '0;
        end else if (dead && (state != IDLE)) begin
            nextState = DEAD;
            nextOcc   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nextState = WAIT;
                    nextOcc   = '0;
                end
                WAIT, SCORE: begin
                    // SCORE behaves like WAIT so a pipe right behind the last one is caught
                    nextState = WAIT;
                    nextOcc   = '0;
                    if (tick && pipeAtBird) begin
                        nextState = IN_PIPE;
                        nextOcc   = OCC_W'(1);
                    end
                end
                IN_PIPE: begin
                    if (tick) begin
                        if (pipeAtBird) begin
                            if (occ < OCC_W'(MAX_W)) begin
                                nextOcc = occ + OCC_W'(1);
                            end
                        end else begin
                            nextOcc   = '0;
                            nextState = (occ >= OCC_W'(MIN_W)) ? SCORE : WAIT;
                        end
                    end
                end
                DEAD: begin
                    nextState = DEAD;
                    nextOcc   = '0;
                end
                default: begin
                    nextState = IDLE;
                    nextOcc   = '0;
                end
            endcase
        end
    end

    // State register with registered add pulse and saturating pass total
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            occ       <= '0;
            add       <= 1'b0;
            passCount <= '0;
        end else begin
            state <= nextState;
            occ   <= nextOcc;
            add   <= (nextState == SCORE);
            if (!start || (state == IDLE)) begin
                passCount <= '0;
            end else if ((nextState == SCORE) && (passCount != {COUNT_W{1'b1}})) begin
                passCount <= passCount + COUNT_W'(1);
            end
        end
    end

`ifdef PIPE_PASS_STRETCH_EN
    localparam int LED_W = $clog2(STRETCH + 1);

    logic [LED_W-1:0] ledCnt;

    // Down-counter reloaded on every add pulse; the LED is lit while it is non-zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ledCnt <= '0;
        end else if (!start) begin
            ledCnt <= '0;
        end else if (nextState == SCORE) begin
            ledCnt <= LED_W'(STRETCH);
        end else if (ledCnt != '0) begin
            ledCnt <= ledCnt - LED_W'(1);
        end
    end

    assign passLed = (ledCnt != '0);
`else
    logic unusedStretch;
    assign unusedStretch = ^STRETCH;
`endif

endmodule

// File: tb/tb_pipe_pass_detector.sv
// tb_pipe_pass_detector: scoreboard bench. Stimulus pushes the reference
// model's expected outputs into a queue at each clock edge; a monitor pops
// and compares on the falling edge. Honours PIPE_PASS_STRETCH_EN for passLed.
module tb_pipe_pass_detector;

    localparam int MIN_W   = 2;
    localparam int MAX_W   = 4;
    localparam int COUNT_W = 3;
    localparam int STRETCH = 4;
    localparam int CNT_MAX = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               dead;
    logic               tick;
    logic               pipeAtBird;
    logic               add;
    logic [COUNT_W-1:0] passCount;
`ifdef PIPE_PASS_STRETCH_EN
    logic               passLed;
`endif

    pipe_pass_detector #(
        .MIN_W(MIN_W),
        .MAX_W(MAX_W),
        .COUNT_W(COUNT_W),
        .STRETCH(STRETCH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dead(dead),
        .tick(tick),
        .pipeAtBird(pipeAtBird),
        .add(add),
        .passCount(passCount)
`ifdef PIPE_PASS_STRETCH_EN
        ,
        .passLed(passLed)
`endif
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        int addV;
        int countV;
        int ledV;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: game running / game over flags, current pipe run length
    bit   mRunning = 0;
    bit   mOver    = 0;
    int   mRun     = 0;
    int   mCount   = 0;
    int   mLed     = 0;

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    function automatic void modelReset();
        mRunning = 0;
        mOver    = 0;
        mRun     = 0;
        mCount   = 0;
        mLed     = 0;
    endfunction

    function automatic void modelStep(input bit s, input bit d, input bit t, input bit p);
        exp_t e;
        int   a;
        a = 0;
        if (!s) begin
            modelReset();
        end else if (!mRunning) begin
            mRunning = 1;
        end else if (d || mOver) begin
            mOver = 1;
            mRun  = 0;
        end else if (t) begin
            if (p) begin
                mRun++;
            end else if (mRun > 0) begin
                if (mRun >= MIN_W) begin
                    a = 1;
                    if (mCount < CNT_MAX) mCount++;
                end
                mRun = 0;
            end
        end
        if (!s)          mLed = 0;
        else if (a == 1) mLed = STRETCH;
        else if (mLed > 0) mLed--;
        e.addV   = a;
        e.countV = mCount;
        e.ledV   = (mLed > 0) ? 1 : 0;
        expQ.push_back(e);
    endfunction

    task automatic applyStimulus(input bit s, input bit d, input bit t, input bit p);
        start      = s;
        dead       = d;
        tick       = t;
        pipeAtBird = p;
        @(posedge clk);
        modelStep(s, d, t, p);
        #1;
    endtask

    task automatic tickSeq(input bit d, input logic [7:0] pattern, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            applyStimulus(1'b1, d, 1'b1, pattern[i]);
        end
    endtask

    // Monitor: pops one expectation per clock and compares away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("add", int'(add), e.addV);
            checkOutput("passCount", int'(passCount), e.countV);
`ifdef PIPE_PASS_STRETCH_EN
            checkOutput("passLed", int'(passLed), e.ledV);
`endif
        end
    end

    initial begin
        bit pipeLevel;
        reset      = 1'b1;
        start      = 1'b0;
        dead       = 1'b0;
        tick       = 1'b0;
        pipeAtBird = 1'b0;
        #1 reset = 1'b0;
        #2;
        checkOutput("reset add", int'(add), 0);
        checkOutput("reset passCount", int'(passCount), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single pipe 1,1,1,0 with idle gaps between ticks
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, (i < 3));
            applyStimulus(1, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0);

        // Glitch pipe 1,0 scores nothing
        tickSeq(0, 8'b10, 2);
        applyStimulus(1, 0, 0, 0);

        // Back-to-back pipes with a tick every cycle
        tickSeq(0, 8'b110110, 6);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0);

        // dead coincides with the exiting tick, then later ticks are ignored
        tickSeq(0, 8'b11, 2);
        applyStimulus(1, 1, 1, 0);
        tickSeq(0, 8'b110110, 6);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Saturation: nine valid passes against a 3-bit total
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) tickSeq(0, 8'b1110, 4);

        // Asynchronous reset while add is high and passCount is saturated
        tickSeq(0, 8'b11, 2);
        applyStimulus(1, 0, 1, 0);
        expQ.delete();
        checkOutput("add before reset", int'(add), 1);
        #2 reset = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("async reset add", int'(add), 0);
        checkOutput("async reset passCount", int'(passCount), 0);
        modelReset();
        @(posedge clk);
        #1 reset = 1'b1;

        // Randomised play with occasional deaths and game restarts
        pipeLevel = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bit s, d, t;
            s = ($urandom_range(0, 79) != 0);
            d = ($urandom_range(0, 149) == 0);
            t = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) pipeLevel = ~pipeLevel;
            applyStimulus(s, d, t, pipeLevel);
        end

        @(negedge clk);
        #1;
        if (expQ.size() != 0) checkOutput("queue drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_pass_detector.md
Name: pipe_pass_detector

Overview:
- Upstream stage of the per-digit score counter.
- Watches the bird's column on the LED field and tracks each pipe as it scrolls through that column.
- Emits a single-cycle `add` pulse when a pipe has fully cleared the bird without a collision. `add` drives the ones-digit score stage directly.
- Also keeps a binary running pass total for debug and high-score logic.

Parameters:
- MIN_W, default 2: minimum consecutive ticks a pipe must occupy the bird column to count as a real pipe. Shorter occupancy is treated as a glitch.
- MAX_W, default 4: saturation value of the occupancy counter.
- COUNT_W, default 8: width of `passCount`.
- STRETCH, default 50000000: `passLed` hold length in clk cycles. Used only with PIPE_PASS_STRETCH_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low (asserted when 0).
- start, input, 1: game running. Low forces IDLE synchronously.
- dead, input, 1: collision / game over, level.
- tick, input, 1: one-cycle strobe, pipes shift one column.
- pipeAtBird, input, 1: pipe segment present in bird column. Sampled only when `tick` = 1.
- add, output, 1: one-cycle score pulse to the score digit.
- passCount, output, COUNT_W: total pipes passed this game, saturating.
- passLed, output, 1: stretched pass indicator. Present only with PIPE_PASS_STRETCH_EN.

Behaviour:
- Reset (reset=0, async): state=IDLE, add=0, passCount=0, occupancy counter occ=0, passLed=0.
- States: IDLE, WAIT, IN_PIPE, SCORE, DEAD. Next-state logic is combinational; all outputs are registered.
- Priority each cycle: start=0 > dead=1 > tick handling.
  - start=0 in any state: go to IDLE next cycle; passCount <= 0; occ <= 0.
  - dead=1 with start=1, from any state except IDLE: go to DEAD.
- IDLE: start=1 -> WAIT. passCount is held at 0 while in IDLE.
- WAIT, on tick:
  - pipeAtBird=1 -> IN_PIPE, occ <= 1.
  - pipeAtBird=0 -> stay.
  - Non-tick cycles: no change.
- IN_PIPE, on tick:
  - pipeAtBird=1 -> occ <= min(occ+1, MAX_W), stay.
  - pipeAtBird=0 and occ >= MIN_W -> SCORE.
  - pipeAtBird=0 and occ < MIN_W -> WAIT, no score.
  - occ clears to 0 on leaving IN_PIPE.
- SCORE: lasts exactly one cycle, then WAIT.
  - add=1 is registered high for exactly the cycle the FSM is in SCORE, i.e. the first cycle after the exiting tick edge. Latency is 1 clk.
  - passCount <= passCount+1 on entry to SCORE, saturating at 2^COUNT_W-1.
  - A tick arriving while in SCORE is processed as in WAIT, so back-to-back pipes are not lost.
- DEAD: add=0; passCount frozen; ignores tick. Leaves only via start=0 -> IDLE.
- dead and the exiting tick in the same cycle: dead wins; no add; passCount unchanged.
- add is never high for two consecutive cycles.
- Mid-operation reset: all state clears immediately, independent of clk.

Optional Feature:
- Macro: PIPE_PASS_STRETCH_EN.
- When defined:
  - `passLed` port exists, driven by a down-counter of width $clog2(STRETCH+1).
  - Every add pulse loads STRETCH; passLed=1 while the counter is non-zero.
  - A new add during the stretch reloads the counter.
  - start=0 or reset clears the counter.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, start=1, ticks with pipeAtBird=1,1,1,0 -> exactly one add pulse, 1 cycle after the 4th tick; passCount=1.
- Glitch: ticks with pipeAtBird=1,0 (occ=1 < MIN_W=2) -> no add; passCount stays 0; FSM back in WAIT.
- Back-to-back pipes: 1,1,0,1,1,0 with a tick on every cycle -> two add pulses, each 1 cycle wide, non-adjacent; passCount=2.
- dead=1 on the same cycle as the exiting tick (pipeAtBird=0 after 1,1) -> no add; later ticks ignored; passCount frozen. Then start=0 -> IDLE next cycle, passCount=0.
- Saturation with COUNT_W=2: 5 valid passes -> passCount ends at 3; add still pulses 5 times.
- Async reset: pull reset low mid-IN_PIPE between clk edges -> add, passCount and occ go to 0 immediately. With PIPE_PASS_STRETCH_EN and STRETCH=4, a single add yields passLed high for exactly 4 cycles.
